// File: rtl/param_counter.sv
// Free-running modulo-UPPER_BOUND counter with a one-cycle wrap flag.
// Typical use: scan-digit select of the 8-digit segment controller (UPPER_BOUND=8).
module param_counter #(
   parameter  int UPPER_BOUND = 8,
   localparam int WIDTH       = (UPPER_BOUND > 2) ? $clog2(UPPER_BOUND) : 1
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] cnt,
   output logic             wrap
);

   if (UPPER_BOUND < 2) begin : g_bad_bound
      $error("param_counter: UPPER_BOUND must be at least 2");
   end

   localparam logic [WIDTH-1:0] TOP = WIDTH'(UPPER_BOUND - 1);

   logic [WIDTH-1:0] cnt_next;
   logic             wrap_next;

   // Explicit terminal compare: out-of-range values fall into the else
   // branch and return to 0 without raising wrap.
   always_comb begin
      cnt_next  = '0;
      wrap_next = 1'b0;
      if (cnt < TOP) begin
         cnt_next = cnt + WIDTH'(1);
      end else begin
         cnt_next  = '0;
         wrap_next = (cnt == TOP);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= '0;
         wrap <= 1'b0;
      end else begin
         cnt  <= cnt_next;
         wrap <= wrap_next;
      end
   end

endmodule

// File: tb/tb_param_counter.sv
// Randomized reset/run bench for param_counter at UPPER_BOUND = 8, 5 and 2,
// checked against a cycles-since-reset arithmetic model.
module tb_param_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] cnt8;
   logic [2:0] cnt5;
   logic [0:0] cnt2;
   logic       wrap8, wrap5, wrap2;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;     // rising edges seen since the last reset release
   int last_wrap = -1;

   always #5 clk = ~clk;

   param_counter #(.UPPER_BOUND(8)) dut8 (.clk(clk), .rst(rst), .cnt(cnt8), .wrap(wrap8));
   param_counter #(.UPPER_BOUND(5)) dut5 (.clk(clk), .rst(rst), .cnt(cnt5), .wrap(wrap5));
   param_counter #(.UPPER_BOUND(2)) dut2 (.clk(clk), .rst(rst), .cnt(cnt2), .wrap(wrap2));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cyc=%0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] exp_wrap(input int ub);
      return (cyc > 0 && (cyc % ub) == 0) ? 32'd1 : 32'd0;
   endfunction

   task automatic check_model(input string tag);
      check({tag, "_cnt8"},  cnt8,  cyc % 8);
      check({tag, "_wrap8"}, wrap8, exp_wrap(8));
      check({tag, "_cnt5"},  cnt5,  cyc % 5);
      check({tag, "_wrap5"}, wrap5, exp_wrap(5));
      check({tag, "_rng5"},  (cnt5 < 3'd5) ? 32'd1 : 32'd0, 32'd1);
      check({tag, "_cnt2"},  cnt2,  cyc % 2);
      check({tag, "_wrap2"}, wrap2, exp_wrap(2));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_cnt8"},  cnt8,  0);
      check({tag, "_wrap8"}, wrap8, 0);
      check({tag, "_cnt5"},  cnt5,  0);
      check({tag, "_wrap5"}, wrap5, 0);
      check({tag, "_cnt2"},  cnt2,  0);
      check({tag, "_wrap2"}, wrap2, 0);
   endtask

   // One clock; outputs sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_model("run");
      if (wrap8 === 1'b1) begin
         if (last_wrap >= 0) check("wrap8_gap", cyc - last_wrap, 8);
         last_wrap = cyc;
      end
   endtask

   // Assert reset between edges, verify the clear is immediate, hold, release.
   task automatic reset_pulse(input int hold);
      #2 rst = 1'b0;
      #1 check_zero("async_clr");
      repeat (hold) begin
         @(negedge clk);
         check_zero("rst_hold");
      end
      @(negedge clk);
      rst = 1'b1;
      cyc = 0;
      last_wrap = -1;
   endtask

   initial begin
      int n;
      #3 check_zero("por");
      @(negedge clk);
      rst = 1'b1;
      cyc = 0;
      repeat (20) step();
      $display("txn directed_run: 20 clocks, cnt8=%0d cnt5=%0d cnt2=%0d", cnt8, cnt5, cnt2);

      while ((cyc % 8) != 5) step();
      check("mid_cnt8_is5", cnt8, 5);
      reset_pulse(0);
      $display("txn mid_count_reset: cleared from cnt8=5");
      step();
      $display("txn first_edge: cnt8=%0d wrap8=%0d", cnt8, wrap8);

      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 4) == 0) begin
            n = $urandom_range(0, 2);
            reset_pulse(n);
            $display("txn %0d: reset pulse, hold=%0d edges", t, n);
         end else begin
            n = $urandom_range(1, 20);
            repeat (n) step();
            $display("txn %0d: run %0d clocks, cyc=%0d cnt8=%0d cnt5=%0d cnt2=%0d",
                     t, n, cyc, cnt8, cnt5, cnt2);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
